// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: widths, ALU op codes, operand-select
// encodings and the output/skid handshake state.
package rv32_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 6;

    localparam logic [ALU_OP_W-1:0] ALU_NOP  = 6'b000000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'b011001;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'b011011;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'b011101;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'b011111;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'b100001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'b100011;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 6'b100101;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 6'b100111;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 6'b101001;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'b101011;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } ex_state_e;
endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU; unrecognised op codes produce zero.
module alu #(
    parameter int DATA_WIDTH = rv32_pkg::DATA_WIDTH
) (
    input  logic [5:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);
    import rv32_pkg::*;

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/ex_fwd_mux.sv
// One ALU operand: pc/imm select, else forwarded register value with the
// older in-stage beat taking priority over writeback.
module ex_fwd_mux #(
    parameter int DATA_WIDTH = rv32_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = rv32_pkg::REG_ADDR_W
) (
    input  logic                  alt_sel,
    input  logic [DATA_WIDTH-1:0] alt_data,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic                  ex_hit_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] operand
);
    always_comb begin
        operand = rs_data;
        if (alt_sel) begin
            operand = alt_data;
        end else if (rs_addr != '0) begin
            // x0 is hardwired; no producer may override it
            if (ex_hit_en && (ex_rd == rs_addr))
                operand = ex_data;
            else if (wb_we && (wb_rd == rs_addr))
                operand = wb_data;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarded operands, ALU, and a registered output with a
// one-entry skid so o_ready never depends combinationally on i_ready.
module ex_stage #(
    parameter int DATA_WIDTH = rv32_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = rv32_pkg::REG_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_alu_op,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic                  i_src_a_sel,
    input  logic                  i_src_b_sel,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_rd_we,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_rd_we
);
    import rv32_pkg::*;

    ex_state_e             state;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] out_result, skid_result;
    logic [REG_ADDR_W-1:0] out_rd, skid_rd;
    logic                  out_we, skid_we;

    logic                  accept;
    logic                  ex_hit_en;
    logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
    logic                  new_we;

    assign accept    = i_valid && rdy_q;
    assign ex_hit_en = o_valid && out_we;
    assign new_we    = i_rd_we && (i_rd != '0);

    ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .alt_sel   (i_src_a_sel == SRC_A_PC),
        .alt_data  (i_pc),
        .rs_addr   (i_rs1_addr),
        .rs_data   (i_rs1_data),
        .ex_hit_en (ex_hit_en),
        .ex_rd     (out_rd),
        .ex_data   (out_result),
        .wb_we     (i_wb_we),
        .wb_rd     (i_wb_rd),
        .wb_data   (i_wb_data),
        .operand   (op_a)
    );

    ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .alt_sel   (i_src_b_sel == SRC_B_IMM),
        .alt_data  (i_imm),
        .rs_addr   (i_rs2_addr),
        .rs_data   (i_rs2_data),
        .ex_hit_en (ex_hit_en),
        .ex_rd     (out_rd),
        .ex_data   (out_result),
        .wb_we     (i_wb_we),
        .wb_rd     (i_wb_rd),
        .wb_data   (i_wb_data),
        .operand   (op_b)
    );

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (i_alu_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_EMPTY;
            rdy_q       <= 1'b1;
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
        end else if (i_flush) begin
            // result/rd are left as-is; only the beat's side effects are killed
            state  <= ST_EMPTY;
            rdy_q  <= 1'b1;
            out_we <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_result <= alu_res;
                        out_rd     <= i_rd;
                        out_we     <= new_we;
                        state      <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        if (accept) begin
                            out_result <= alu_res;
                            out_rd     <= i_rd;
                            out_we     <= new_we;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end else if (accept) begin
                        skid_result <= alu_res;
                        skid_rd     <= i_rd;
                        skid_we     <= new_we;
                        state       <= ST_SKID;
                        rdy_q       <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (i_ready) begin
                        out_result <= skid_result;
                        out_rd     <= skid_rd;
                        out_we     <= skid_we;
                        state      <= ST_FULL;
                        rdy_q      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = rdy_q;
    assign o_valid  = (state != ST_EMPTY);
    assign o_result = out_result;
    assign o_rd     = out_rd;
    assign o_rd_we  = out_we;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding priority, x0, skid backpressure,
// flush and asynchronous reset.
module tb_ex_stage;
    import rv32_pkg::*;

    logic        i_clk, i_rst_n, i_valid, o_ready;
    logic [5:0]  i_alu_op;
    logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm, i_wb_data, o_result;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd, i_wb_rd, o_rd;
    logic        i_src_a_sel, i_src_b_sel, i_rd_we, i_wb_we, i_flush;
    logic        o_valid, i_ready, o_rd_we;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_op(i_alu_op), .i_pc(i_pc), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_src_a_sel(i_src_a_sel), .i_src_b_sel(i_src_b_sel), .i_rd(i_rd), .i_rd_we(i_rd_we),
        .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rd(o_rd), .o_rd_we(o_rd_we)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic sb,
                         input logic [4:0] rd, input logic we);
        i_valid = v; i_alu_op = op;
        i_rs1_addr = r1; i_rs1_data = d1; i_rs2_addr = r2; i_rs2_data = d2;
        i_imm = imm; i_src_a_sel = SRC_A_RS1; i_src_b_sel = sb; i_pc = '0;
        i_rd = rd; i_rd_we = we;
        i_wb_we = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    endtask

    task automatic idle();
        drive(1'b0, ALU_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        idle();
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", o_result); end
        checks++; if (o_rd !== 5'd0 || o_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd: got rd=%0d we=%b want 0/0", o_rd, o_rd_we); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        @(negedge i_clk) i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_add();
        drive(1'b1, ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, SRC_B_RS2, 5'd3, 1'b1);
        step();
        idle();
        checks++; if (o_valid !== 1'b1 || o_result !== 32'd12) begin errors++; $display("FAIL add_result: got v=%b res=%h want 1/0000000c", o_valid, o_result); end
        checks++; if (o_rd !== 5'd3 || o_rd_we !== 1'b1) begin errors++; $display("FAIL add_rd: got rd=%0d we=%b want 3/1", o_rd, o_rd_we); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  ops [11] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
                                  ALU_SLL, ALU_SRL, ALU_SRA, 6'b111111, ALU_NOP};
        logic [31:0] as  [11] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd1, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        logic [31:0] bs  [11] = '{32'd7, 32'hFF00, 32'hFF00, 32'hFF00, 32'd1, 32'd1,
                                  32'd31, 32'd31, 32'd31, 32'd7, 32'd7};
        logic [31:0] exp [11] = '{32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'h0FF0, 32'd1, 32'd0,
                                  32'h80000000, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, ops[k], 5'd1, as[k], 5'd2, bs[k], 32'd0, SRC_B_RS2, 5'd7, 1'b1);
            step();
            checks++;
            if (o_valid !== 1'b1 || o_result !== exp[k]) begin
                errors++; $display("FAIL alu_op%0d: got v=%b res=%h want 1/%h", k, o_valid, o_result, exp[k]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_forwarding();
        drive(1'b1, ALU_ADD, 5'd1, 32'h8, 5'd2, 32'h8, 32'd0, SRC_B_RS2, 5'd4, 1'b1);
        step();
        checks++; if (o_result !== 32'h10) begin errors++; $display("FAIL fwd_a_result: got %h want 00000010", o_result); end
        // older in-stage beat beats a concurrent writeback to the same register
        drive(1'b1, ALU_SUB, 5'd4, 32'hDEAD, 5'd2, 32'd1, 32'd0, SRC_B_RS2, 5'd5, 1'b1);
        i_wb_we = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'h99;
        step();
        checks++; if (o_result !== 32'h0F) begin errors++; $display("FAIL fwd_ex_prio: got %h want 0000000f", o_result); end
        drive(1'b1, ALU_ADD, 5'd6, 32'd1, 5'd5, 32'h555, 32'd3, SRC_B_IMM, 5'd8, 1'b1);
        i_wb_we = 1'b1; i_wb_rd = 5'd6; i_wb_data = 32'h100;
        step();
        checks++; if (o_result !== 32'h103) begin errors++; $display("FAIL fwd_wb_imm: got %h want 00000103", o_result); end
        drive(1'b1, ALU_ADD, 5'd8, 32'hBAD, 5'd0, 32'd0, 32'h20, SRC_B_IMM, 5'd9, 1'b1);
        i_src_a_sel = SRC_A_PC; i_pc = 32'h1000;
        step();
        checks++; if (o_result !== 32'h1020) begin errors++; $display("FAIL pc_path: got %h want 00001020", o_result); end
        idle();
        step();
    endtask

    task automatic test_x0();
        drive(1'b1, ALU_ADD, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, SRC_B_RS2, 5'd0, 1'b1);
        step();
        checks++; if (o_rd_we !== 1'b0 || o_result !== 32'h33) begin errors++; $display("FAIL x0_we: got we=%b res=%h want 0/00000033", o_rd_we, o_result); end
        drive(1'b1, ALU_ADD, 5'd0, 32'd0, 5'd2, 32'd5, 32'd0, SRC_B_RS2, 5'd3, 1'b1);
        i_wb_we = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h77;
        step();
        checks++; if (o_result !== 32'd5) begin errors++; $display("FAIL x0_nofwd: got %h want 00000005", o_result); end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        drive(1'b1, ALU_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd8, 1'b1);
        step();
        checks++; if (o_valid !== 1'b1 || o_result !== 32'd1 || o_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got v=%b res=%h rdy=%b want 1/1/1", o_valid, o_result, o_ready); end
        drive(1'b1, ALU_ADD, 5'd1, 32'd2, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd9, 1'b1);
        step();
        checks++; if (o_ready !== 1'b0 || o_result !== 32'd1 || o_rd !== 5'd8) begin errors++; $display("FAIL bp_skid: got rdy=%b res=%h rd=%0d want 0/1/8", o_ready, o_result, o_rd); end
        drive(1'b1, ALU_ADD, 5'd1, 32'd3, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd10, 1'b1);
        step();
        checks++; if (o_ready !== 1'b0 || o_result !== 32'd1 || o_valid !== 1'b1) begin errors++; $display("FAIL bp_stall: got rdy=%b res=%h v=%b want 0/1/1", o_ready, o_result, o_valid); end
        i_ready = 1'b1;
        step();
        checks++; if (o_result !== 32'd2 || o_rd !== 5'd9 || o_ready !== 1'b1) begin errors++; $display("FAIL bp_out2: got res=%h rd=%0d rdy=%b want 2/9/1", o_result, o_rd, o_ready); end
        step();
        idle();
        checks++; if (o_result !== 32'd3 || o_rd !== 5'd10 || o_valid !== 1'b1) begin errors++; $display("FAIL bp_out3: got res=%h rd=%0d v=%b want 3/10/1", o_result, o_rd, o_valid); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        drive(1'b1, ALU_ADD, 5'd1, 32'hA1, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd11, 1'b1);
        step();
        drive(1'b1, ALU_ADD, 5'd1, 32'hA2, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd12, 1'b1);
        step();
        drive(1'b1, ALU_ADD, 5'd1, 32'hA3, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd13, 1'b1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_ready = 1'b1;
        idle();
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_rd_we !== 1'b0) begin errors++; $display("FAIL flush_skid: got v=%b rdy=%b we=%b want 0/1/0", o_valid, o_ready, o_rd_we); end
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: got %b want 0", o_valid); end
        // flush in FULL with a concurrent accept
        drive(1'b1, ALU_ADD, 5'd1, 32'hB1, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd14, 1'b1);
        step();
        drive(1'b1, ALU_ADD, 5'd1, 32'hB2, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd15, 1'b1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", o_valid); end
        drive(1'b1, ALU_ADD, 5'd1, 32'hC4, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd16, 1'b1);
        step();
        idle();
        checks++; if (o_valid !== 1'b1 || o_result !== 32'hC4 || o_rd !== 5'd16) begin errors++; $display("FAIL flush_resume: got v=%b res=%h rd=%0d want 1/c4/16", o_valid, o_result, o_rd); end
        step();
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        drive(1'b1, ALU_ADD, 5'd1, 32'h55, 5'd0, 32'd0, 32'd0, SRC_B_RS2, 5'd17, 1'b1);
        step();
        idle();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", o_valid); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_rd_we !== 1'b0 || o_result !== 32'h0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_async: got v=%b we=%b res=%h rdy=%b want 0/0/0/1", o_valid, o_rd_we, o_result, o_ready);
        end
        @(negedge i_clk) i_rst_n = 1'b1;
        i_ready = 1'b1;
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_post: got %b want 0", o_valid); end
        drive(1'b1, ALU_SRA, 5'd1, 32'h80000000, 5'd0, 32'd0, 32'd4, SRC_B_IMM, 5'd18, 1'b1);
        step();
        idle();
        checks++; if (o_valid !== 1'b1 || o_result !== 32'hF8000000) begin errors++; $display("FAIL sra_imm: got v=%b res=%h want 1/f8000000", o_valid, o_result); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_alu_ops();
        test_forwarding();
        test_x0();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
